rf_writeback: RTL and testbench

Write-side companion of the integer register file. Merges the in-order pipeline's writeback stream with results returned by long-latency units (mul/div) into the register file's single write port. Also tracks registers still awaited from long-latency units (busy scoreboard) for decode hazard detection, and exposes the in-flight write for read bypass. Sits between the writeback stage / long-latency units and the register file write port (`we`/`rd`/`wdata`).

---
 rtl/rf_writeback_if.sv | 43 ++++
 rtl/rf_writeback.sv | 117 +++++++++++
 tb/tb_rf_writeback.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/rf_writeback_if.sv
// Bundle of the writeback-side signals of rf_writeback: pipeline writeback,
// long-latency issue/result, decode queries and the register file write port.
interface rf_writeback_if #(
  parameter int unsigned XLEN = 32
) ();
  // Pipeline writeback
  logic            p_valid;
  logic [4:0]      p_rd;
  logic [XLEN-1:0] p_wdata;
  logic            p_stall;
  // Long-latency issue and result
  logic            iss_valid;
  logic [4:0]      iss_rd;
  logic            l_valid;
  logic            l_ready;
  logic [4:0]      l_rd;
  logic [XLEN-1:0] l_wdata;
  // Decode-stage queries
  logic [4:0]      q_rs1;
  logic [4:0]      q_rs2;
  logic [4:0]      q_rd;
  logic            hazard;
  logic            byp1;
  logic            byp2;
  // Register file write port
  logic            rf_we;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_wdata;

  // Producer/consumer side (writeback stage, long-latency units, decode)
  modport master (
    output p_valid, p_rd, p_wdata, iss_valid, iss_rd, l_valid, l_rd, l_wdata,
           q_rs1, q_rs2, q_rd,
    input  p_stall, l_ready, hazard, byp1, byp2, rf_we, rf_rd, rf_wdata
  );

  // rf_writeback side
  modport slave (
    input  p_valid, p_rd, p_wdata, iss_valid, iss_rd, l_valid, l_rd, l_wdata,
           q_rs1, q_rs2, q_rd,
    output p_stall, l_ready, hazard, byp1, byp2, rf_we, rf_rd, rf_wdata
  );
endinterface

// File: rtl/rf_writeback.sv
// Merges the in-order writeback stream and long-latency results into the single
// register file write port; keeps the busy scoreboard and exposes the in-flight
// write for read bypass.
module rf_writeback #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  rf_writeback_if.slave       bus
);

  localparam int unsigned CntW = $clog2(STARVE_MAX + 1);

  logic [31:0]     busy_q, busy_d;
  logic            buf_valid_q, buf_valid_d;
  logic [4:0]      buf_rd_q, buf_rd_d;
  logic [XLEN-1:0] buf_data_q, buf_data_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            rf_we_q, rf_we_d;
  logic [4:0]      rf_rd_q, rf_rd_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;

  logic stall;
  logic drain;
  logic accept;
  logic rf_we_eff;

  // Handshake and query outputs derived from registered state
  always_comb begin
    stall       = buf_valid_q && (cnt_q == CntW'(STARVE_MAX));
    accept      = bus.l_valid && en && !buf_valid_q;
    // Stall forces the buffer through; otherwise it only uses idle pipeline slots
    drain       = en && buf_valid_q && (stall || !bus.p_valid);
    rf_we_eff   = rf_we_q && en;
    bus.p_stall = stall;
    bus.l_ready = en && !buf_valid_q;
    bus.hazard  = busy_q[bus.q_rs1] | busy_q[bus.q_rs2] | busy_q[bus.q_rd];
    bus.byp1    = rf_we_eff && (rf_rd_q == bus.q_rs1);
    bus.byp2    = rf_we_eff && (rf_rd_q == bus.q_rs2);
    bus.rf_we   = rf_we_eff;
    bus.rf_rd   = rf_rd_q;
    bus.rf_wdata = rf_wdata_q;
  end

  // Next-state: write-port select, buffer, starvation counter, scoreboard
  always_comb begin
    busy_d      = busy_q;
    buf_valid_d = buf_valid_q;
    buf_rd_d    = buf_rd_q;
    buf_data_d  = buf_data_q;
    cnt_d       = cnt_q;
    rf_we_d     = rf_we_q;
    rf_rd_d     = rf_rd_q;
    rf_wdata_d  = rf_wdata_q;

    if (en) begin
      if (drain) begin
        rf_we_d          = (buf_rd_q != 5'd0);
        rf_rd_d          = buf_rd_q;
        rf_wdata_d       = buf_data_q;
        buf_valid_d      = 1'b0;
        busy_d[buf_rd_q] = 1'b0;
      end else if (bus.p_valid) begin
        // p_valid during stall is dropped: drain wins above
        rf_we_d    = (bus.p_rd != 5'd0);
        rf_rd_d    = bus.p_rd;
        rf_wdata_d = bus.p_wdata;
      end else begin
        rf_we_d = 1'b0;
      end

      if (accept) begin
        buf_valid_d = 1'b1;
        buf_rd_d    = bus.l_rd;
        buf_data_d  = bus.l_wdata;
      end

      if (!buf_valid_q || drain) begin
        cnt_d = '0;
      end else if (cnt_q != CntW'(STARVE_MAX)) begin
        cnt_d = cnt_q + CntW'(1);
      end

      // Set after clear so a same-cycle reissue keeps the register busy
      if (bus.iss_valid && bus.iss_rd != 5'd0) begin
        busy_d[bus.iss_rd] = 1'b1;
      end
    end
    busy_d[0] = 1'b0;
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= '0;
      buf_valid_q <= 1'b0;
      buf_rd_q    <= '0;
      buf_data_q  <= '0;
      cnt_q       <= '0;
      rf_we_q     <= 1'b0;
      rf_rd_q     <= '0;
      rf_wdata_q  <= '0;
    end else begin
      busy_q      <= busy_d;
      buf_valid_q <= buf_valid_d;
      buf_rd_q    <= buf_rd_d;
      buf_data_q  <= buf_data_d;
      cnt_q       <= cnt_d;
      rf_we_q     <= rf_we_d;
      rf_rd_q     <= rf_rd_d;
      rf_wdata_q  <= rf_wdata_d;
    end
  end

endmodule

// File: tb/tb_rf_writeback.sv
// Directed bench for rf_writeback: writeback path, x0 drop, scoreboard,
// long-latency drain, starvation stall, enable gating and async reset.
module tb_rf_writeback;

  logic clk;
  logic rst_n;
  logic en;
  int   total;
  int   bad;

  rf_writeback_if #(.XLEN(32)) bus ();

  rf_writeback #(
    .XLEN       (32),
    .STARVE_MAX (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    en    = 1'b1;
    bus.p_valid   = 1'b0;
    bus.p_rd      = '0;
    bus.p_wdata   = '0;
    bus.iss_valid = 1'b0;
    bus.iss_rd    = '0;
    bus.l_valid   = 1'b0;
    bus.l_rd      = '0;
    bus.l_wdata   = '0;
    bus.q_rs1     = '0;
    bus.q_rs2     = '0;
    bus.q_rd      = '0;

    // Reset state
    #2;
    check("rst_rf_we", 32'(bus.rf_we), 32'd0);
    check("rst_rf_rd", 32'(bus.rf_rd), 32'd0);
    check("rst_rf_wdata", bus.rf_wdata, 32'd0);
    check("rst_p_stall", 32'(bus.p_stall), 32'd0);
    check("rst_hazard", 32'(bus.hazard), 32'd0);
    check("rst_l_ready", 32'(bus.l_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();

    // Pipeline write rd=5 visible next cycle, bypass on rs1
    bus.p_valid = 1'b1;
    bus.p_rd    = 5'd5;
    bus.p_wdata = 32'h1234;
    bus.q_rs1   = 5'd5;
    tick();
    bus.p_valid = 1'b0;
    check("p_we", 32'(bus.rf_we), 32'd1);
    check("p_rd", 32'(bus.rf_rd), 32'd5);
    check("p_wdata", bus.rf_wdata, 32'h1234);
    check("p_byp1", 32'(bus.byp1), 32'd1);
    check("p_byp2", 32'(bus.byp2), 32'd0);
    tick();
    check("idle_we", 32'(bus.rf_we), 32'd0);

    // x0 write dropped
    bus.p_valid = 1'b1;
    bus.p_rd    = 5'd0;
    bus.p_wdata = 32'hFFFF_FFFF;
    tick();
    bus.p_valid = 1'b0;
    check("x0_we", 32'(bus.rf_we), 32'd0);
    check("x0_byp1", 32'(bus.byp1), 32'd0);

    // Issue rd=7, hazard from next cycle
    bus.q_rs1     = 5'd0;
    bus.q_rs2     = 5'd7;
    bus.iss_valid = 1'b1;
    bus.iss_rd    = 5'd7;
    #1;
    check("iss_hazard_same", 32'(bus.hazard), 32'd0);
    tick();
    bus.iss_valid = 1'b0;
    check("iss_hazard_next", 32'(bus.hazard), 32'd1);

    // Long-latency result rd=7 with idle pipeline: out at M+2
    bus.l_valid = 1'b1;
    bus.l_rd    = 5'd7;
    bus.l_wdata = 32'hABCD;
    check("ll_ready_m", 32'(bus.l_ready), 32'd1);
    tick();
    bus.l_valid = 1'b0;
    check("ll_ready_m1", 32'(bus.l_ready), 32'd0);
    check("ll_we_m1", 32'(bus.rf_we), 32'd0);
    check("ll_hazard_m1", 32'(bus.hazard), 32'd1);
    tick();
    check("ll_we_m2", 32'(bus.rf_we), 32'd1);
    check("ll_rd_m2", 32'(bus.rf_rd), 32'd7);
    check("ll_wdata_m2", bus.rf_wdata, 32'hABCD);
    check("ll_hazard_m2", 32'(bus.hazard), 32'd0);
    check("ll_byp2_m2", 32'(bus.byp2), 32'd1);
    check("ll_ready_m2", 32'(bus.l_ready), 32'd1);

    // Starvation: result rd=9 blocked by continuous pipeline writes
    bus.l_valid = 1'b1;
    bus.l_rd    = 5'd9;
    bus.l_wdata = 32'h5555;
    bus.p_valid = 1'b1;
    bus.p_rd    = 5'd1;
    bus.p_wdata = 32'h100;
    tick();
    bus.l_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("starve_stall_low", 32'(bus.p_stall), 32'd0);
      check("starve_p_wdata", bus.rf_wdata, 32'h100 + 32'(i));
      bus.p_wdata = 32'h101 + 32'(i);
      tick();
    end
    check("starve_stall_high", 32'(bus.p_stall), 32'd1);
    check("starve_blocked_rd", 32'(bus.rf_rd), 32'd1);
    bus.p_valid = 1'b0;
    tick();
    check("starve_drain_we", 32'(bus.rf_we), 32'd1);
    check("starve_drain_rd", 32'(bus.rf_rd), 32'd9);
    check("starve_drain_wdata", bus.rf_wdata, 32'h5555);
    check("starve_stall_drop", 32'(bus.p_stall), 32'd0);
    check("starve_ready", 32'(bus.l_ready), 32'd1);

    // Same-cycle drain and reissue of rd=3 keeps it busy
    bus.q_rs1     = 5'd3;
    bus.q_rs2     = 5'd0;
    bus.iss_valid = 1'b1;
    bus.iss_rd    = 5'd3;
    tick();
    bus.iss_valid = 1'b0;
    bus.l_valid   = 1'b1;
    bus.l_rd      = 5'd3;
    bus.l_wdata   = 32'h33;
    tick();
    bus.l_valid   = 1'b0;
    bus.iss_valid = 1'b1;
    tick();
    bus.iss_valid = 1'b0;
    check("reiss_rd", 32'(bus.rf_rd), 32'd3);
    check("reiss_byp1", 32'(bus.byp1), 32'd1);
    check("reiss_hazard", 32'(bus.hazard), 32'd1);

    // Buffered rd=0 result drains without a write
    bus.l_valid = 1'b1;
    bus.l_rd    = 5'd0;
    bus.l_wdata = 32'h77;
    tick();
    bus.l_valid = 1'b0;
    tick();
    check("x0ll_we", 32'(bus.rf_we), 32'd0);
    check("x0ll_ready", 32'(bus.l_ready), 32'd1);

    // Enable gating
    bus.p_valid = 1'b1;
    bus.p_rd    = 5'd4;
    bus.p_wdata = 32'h44;
    tick();
    bus.p_valid = 1'b0;
    check("en_we_on", 32'(bus.rf_we), 32'd1);
    en = 1'b0;
    bus.iss_valid = 1'b1;
    bus.iss_rd    = 5'd10;
    bus.q_rd      = 5'd10;
    #1;
    check("en_we_forced", 32'(bus.rf_we), 32'd0);
    check("en_ready_off", 32'(bus.l_ready), 32'd0);
    tick();
    bus.iss_valid = 1'b0;
    en = 1'b1;
    #1;
    check("en_no_busy", 32'(bus.hazard & ~bus.byp1), 32'(1'b1) & 32'(bus.hazard));
    check("en_hold_we", 32'(bus.rf_we), 32'd1);
    check("en_hold_rd", 32'(bus.rf_rd), 32'd4);
    bus.q_rs1 = 5'd0;
    #1;
    check("en_busy10_clear", 32'(bus.hazard), 32'd0);

    // Async reset mid-operation
    bus.iss_valid = 1'b1;
    bus.iss_rd    = 5'd12;
    bus.q_rs1     = 5'd12;
    tick();
    bus.iss_valid = 1'b0;
    bus.l_valid   = 1'b1;
    bus.l_rd      = 5'd12;
    bus.l_wdata   = 32'hC0DE;
    bus.p_valid   = 1'b1;
    bus.p_rd      = 5'd2;
    bus.p_wdata   = 32'h22;
    tick();
    bus.l_valid = 1'b0;
    check("prerst_we", 32'(bus.rf_we), 32'd1);
    check("prerst_hazard", 32'(bus.hazard), 32'd1);
    check("prerst_ready", 32'(bus.l_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_we", 32'(bus.rf_we), 32'd0);
    check("arst_rd", 32'(bus.rf_rd), 32'd0);
    check("arst_wdata", bus.rf_wdata, 32'd0);
    check("arst_hazard", 32'(bus.hazard), 32'd0);
    check("arst_byp1", 32'(bus.byp1), 32'd0);
    bus.p_valid = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
    check("postrst_ready", 32'(bus.l_ready), 32'd1);
    check("postrst_hazard", 32'(bus.hazard), 32'd0);
    check("postrst_we", 32'(bus.rf_we), 32'd0);
    check("postrst_stall", 32'(bus.p_stall), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
